mca_sequencer: RTL and testbench

Drives and consumes the single-channel multi-clock FIR adder interface (start, H_matrix, S_matrix, enable_N, K, sample). Collects incoming control-bit vectors into per-channel history shift registers, decimates by OSR, and on each decimation trigger snapshots the history. It then runs the adder once per active channel, accumulates the returned per-channel samples into one estimate, and emits that estimate with a one-cycle valid.

---
 rtl/mca_sequencer_if.sv | 19 +
 rtl/mca_sequencer.sv | 154 +++++++++++++++
 tb/tb_mca_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mca_sequencer_if.sv
// Adder-side bus of the MCA sequencer: pass control, the coefficient and history
// matrices of the current channel, and the sample returned by the adder.
interface mca_sequencer_if #(
    parameter int unsigned K_MAX             = 512,
    parameter int unsigned WIDTH_COEFFICIENT = 32,
    parameter int unsigned MCA_NUM_ADDITIONS = 16
);
    localparam int unsigned KG_W = K_MAX / MCA_NUM_ADDITIONS;

    logic                                    start;
    logic                                    enable_N;
    logic [KG_W-1:0]                         K;
    logic [K_MAX-1:0][WIDTH_COEFFICIENT-1:0] H_matrix;
    logic [K_MAX-1:0]                        S_matrix;
    logic [WIDTH_COEFFICIENT-1:0]            sample;

    modport master (output start, enable_N, K, H_matrix, S_matrix, input sample);
    modport slave  (input start, enable_N, K, H_matrix, S_matrix, output sample);
endinterface

// File: rtl/mca_sequencer.sv
// Decimating MCA sequencer: keeps per-channel control-bit history, snapshots it every
// OSR vectors and runs the external adder once per active channel to build one estimate.
module mca_sequencer #(
    parameter int unsigned K_MAX             = 512,
    parameter int unsigned N_MAX             = 8,
    parameter int unsigned WIDTH_COEFFICIENT = 32,
    parameter int unsigned MCA_NUM_ADDITIONS = 16,
    parameter int unsigned OSR               = 8,
    parameter int unsigned MCA_LATENCY       = 40
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 s_valid,
    input  logic [N_MAX-1:0]                     s_in,
    input  logic [$clog2(N_MAX+1)-1:0]           N_active,
    input  logic [K_MAX/MCA_NUM_ADDITIONS-1:0]   K_mask,
    input  logic                                 coef_we,
    input  logic [$clog2(N_MAX)-1:0]             coef_ch,
    input  logic [$clog2(K_MAX)-1:0]             coef_idx,
    input  logic signed [WIDTH_COEFFICIENT-1:0]  coef_wdata,
    mca_sequencer_if.master                      adder,
    output logic signed [WIDTH_COEFFICIENT-1:0]  est_out,
    output logic                                 est_valid,
    output logic                                 busy,
    output logic                                 overrun
);
    localparam int unsigned W    = WIDTH_COEFFICIENT;
    localparam int unsigned NA_W = $clog2(N_MAX + 1);
    localparam int unsigned CH_W = $clog2(N_MAX);
    localparam int unsigned KG_W = K_MAX / MCA_NUM_ADDITIONS;
    localparam int unsigned DC_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int unsigned WT_W = $clog2(MCA_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, ACC, DONE} state_t;

    state_t                             r_state;
    state_t                             w_state_nx;
    logic [N_MAX-1:0][K_MAX-1:0]        r_hist;
    logic [N_MAX-1:0][K_MAX-1:0]        r_snap;
    logic [N_MAX-1:0][K_MAX-1:0]        w_hist_nx;
    logic [N_MAX-1:0][K_MAX-1:0][W-1:0] r_coef;
    logic [DC_W-1:0]                    r_dcnt;
    logic [WT_W-1:0]                    r_wcnt;
    logic [CH_W-1:0]                    r_ch;
    logic [NA_W-1:0]                    r_nlat;
    logic [NA_W-1:0]                    w_nclamp;
    logic [KG_W-1:0]                    r_k;
    logic [W-1:0]                       r_acc;
    logic [W-1:0]                       w_acc_nx;
    logic [W-1:0]                       r_est;
    logic                               r_start;
    logic                               r_en;
    logic                               r_est_valid;
    logic                               r_busy;
    logic                               r_overrun;
    logic                               w_trig;
    logic                               w_last;

    assign w_trig   = s_valid && (r_dcnt == DC_W'(OSR - 1));
    assign w_nclamp = (32'(N_active) > N_MAX) ? NA_W'(N_MAX) : N_active;
    assign w_last   = (NA_W'(r_ch) == (r_nlat - NA_W'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nx;
    end

    // Next state, accumulator update and history-with-new-vector view
    always_comb begin
        w_state_nx = r_state;
        w_acc_nx   = r_acc;
        w_hist_nx  = r_hist;
        for (int n = 0; n < N_MAX; n++) begin
            w_hist_nx[n] = {r_hist[n][K_MAX-2:0], s_in[n]};
        end
        unique case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_state_nx = (w_nclamp == '0) ? DONE : LOAD;
                    w_acc_nx   = '0;
                end
            end
            LOAD:  w_state_nx = START;
            START: w_state_nx = WAIT;
            WAIT:  if (r_wcnt == '0) w_state_nx = ACC;
            ACC: begin
                w_acc_nx   = r_acc + adder.sample;
                w_state_nx = w_last ? DONE : LOAD;
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hist      <= '0;
            r_snap      <= '0;
            r_coef      <= '0;
            r_dcnt      <= '0;
            r_wcnt      <= '0;
            r_ch        <= '0;
            r_nlat      <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_est       <= '0;
            r_start     <= 1'b0;
            r_en        <= 1'b0;
            r_est_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (s_valid) begin
                r_hist <= w_hist_nx;
                r_dcnt <= (r_dcnt == DC_W'(OSR - 1)) ? '0 : r_dcnt + DC_W'(1);
            end
            if (w_trig && (r_state != IDLE)) r_overrun <= 1'b1;
            // Coefficients are frozen while a pass is reading them
            if (coef_we && (r_state == IDLE) && (32'(coef_ch) < N_MAX)) begin
                r_coef[coef_ch][coef_idx] <= coef_wdata;
            end
            if ((r_state == IDLE) && w_trig) begin
                r_snap <= w_hist_nx;
                r_nlat <= w_nclamp;
                r_k    <= K_mask;
                r_ch   <= '0;
            end
            if (r_state == START) begin
                r_wcnt <= WT_W'(MCA_LATENCY - 1);
            end else if ((r_state == WAIT) && (r_wcnt != '0)) begin
                r_wcnt <= r_wcnt - WT_W'(1);
            end
            if ((r_state == ACC) && !w_last) r_ch <= r_ch + CH_W'(1);
            r_acc       <= w_acc_nx;
            r_start     <= (w_state_nx == START);
            r_en        <= (w_state_nx == START) || (w_state_nx == WAIT);
            r_busy      <= (w_state_nx != IDLE);
            r_est_valid <= (w_state_nx == DONE);
            if (w_state_nx == DONE) r_est <= w_acc_nx;
        end
    end

    assign adder.start    = r_start;
    assign adder.enable_N = r_en;
    assign adder.K        = r_k;
    assign adder.H_matrix = r_coef[r_ch];
    assign adder.S_matrix = r_snap[r_ch];
    assign est_out        = r_est;
    assign est_valid      = r_est_valid;
    assign busy           = r_busy;
    assign overrun        = r_overrun;
endmodule

// File: tb/tb_mca_sequencer.sv
// Bench for mca_sequencer: behavioural adder on the bus, history/coefficient model and
// an expected-estimate queue checked whenever est_valid pulses.
module tb_mca_sequencer;
    localparam int K_MAX = 32;
    localparam int N_MAX = 8;
    localparam int W     = 32;
    localparam int NA    = 16;
    localparam int OSR   = 4;
    localparam int LAT   = 4;
    localparam int KG_W  = K_MAX / NA;
    localparam int NA_W  = $clog2(N_MAX + 1);
    localparam int CH_W  = $clog2(N_MAX);
    localparam int IX_W  = $clog2(K_MAX);

    logic              clk = 1'b0;
    logic              resetn;
    logic              s_valid;
    logic [N_MAX-1:0]  s_in;
    logic [NA_W-1:0]   N_active;
    logic [KG_W-1:0]   K_mask;
    logic              coef_we;
    logic [CH_W-1:0]   coef_ch;
    logic [IX_W-1:0]   coef_idx;
    logic [W-1:0]      coef_wdata;
    logic [W-1:0]      est_out;
    logic              est_valid;
    logic              busy;
    logic              overrun;

    mca_sequencer_if #(.K_MAX(K_MAX), .WIDTH_COEFFICIENT(W), .MCA_NUM_ADDITIONS(NA)) bus();

    mca_sequencer #(
        .K_MAX(K_MAX), .N_MAX(N_MAX), .WIDTH_COEFFICIENT(W),
        .MCA_NUM_ADDITIONS(NA), .OSR(OSR), .MCA_LATENCY(LAT)
    ) dut (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_in(s_in),
        .N_active(N_active), .K_mask(K_mask), .coef_we(coef_we), .coef_ch(coef_ch),
        .coef_idx(coef_idx), .coef_wdata(coef_wdata), .adder(bus),
        .est_out(est_out), .est_valid(est_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int               n_cmp = 0;
    int               n_err = 0;
    int               n_start = 0;
    int               ns;
    bit               force_max = 1'b0;
    logic [W-1:0]     exp_val[$];
    int               exp_cyc[$];
    logic [K_MAX-1:0] hist_m [N_MAX];
    logic [W-1:0]     coef_m [N_MAX][K_MAX];
    int               dcnt_m;
    int               m_cnt = 0;
    logic [W-1:0]     m_res;
    logic [W-1:0]     mon_v;
    int               mon_c;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Behavioural adder: masked sum of coefficients where the history bit is set
    function automatic logic [W-1:0] adder_sum();
        logic [W-1:0] s = '0;
        for (int k = 0; k < K_MAX; k++)
            if (bus.K[k/NA] && bus.S_matrix[k]) s += bus.H_matrix[k];
        return s;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            m_cnt      <= 0;
            bus.sample <= '0;
        end else if (bus.start) begin
            m_res      <= force_max ? 32'h7FFF_FFFF : adder_sum();
            m_cnt      <= LAT;
            bus.sample <= 32'hBAD0_0BAD;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) bus.sample <= m_res;
        end
    end

    // Scoreboard side: pop one expectation per est_valid pulse
    always @(negedge clk) begin
        if (bus.start) begin
            n_start++;
            chk("enable_with_start", 64'(bus.enable_N), 1);
        end
        if (est_valid) begin
            if (exp_val.size() == 0) begin
                chk("spurious_est_valid", 64'(est_valid), 0);
            end else begin
                mon_v = exp_val.pop_front();
                mon_c = exp_cyc.pop_front();
                chk("est_out", 64'(est_out), 64'(mon_v));
                chk("est_latency", 64'(cyc), 64'(mon_c));
            end
        end
    end

    function automatic logic [W-1:0] exp_est(input int nc, input logic [KG_W-1:0] km);
        logic [W-1:0] s = '0;
        for (int c = 0; c < nc; c++) begin
            if (force_max) s += 32'h7FFF_FFFF;
            else
                for (int k = 0; k < K_MAX; k++)
                    if (km[k/NA] && hist_m[c][k]) s += coef_m[c][k];
        end
        return s;
    endfunction

    task automatic clr_models();
        for (int c = 0; c < N_MAX; c++) begin
            hist_m[c] = '0;
            for (int k = 0; k < K_MAX; k++) coef_m[c][k] = '0;
        end
        dcnt_m = 0;
    endtask

    task automatic vec(input logic [N_MAX-1:0] bits, input int nact,
                       input logic [KG_W-1:0] km, input bit run);
        int nc;
        @(posedge clk); #1;
        s_valid  = 1'b1;
        s_in     = bits;
        N_active = NA_W'(nact);
        K_mask   = km;
        coef_we  = 1'b0;
        for (int c = 0; c < N_MAX; c++) hist_m[c] = {hist_m[c][K_MAX-2:0], bits[c]};
        if (dcnt_m == OSR - 1) begin
            dcnt_m = 0;
            nc = (nact > N_MAX) ? N_MAX : nact;
            if (run) begin
                exp_val.push_back(exp_est(nc, km));
                exp_cyc.push_back(cyc + 1 + nc * (LAT + 3));
            end
        end else begin
            dcnt_m++;
        end
    endtask

    task automatic burst(input logic [N_MAX-1:0] bits, input int nact,
                         input logic [KG_W-1:0] km, input bit run);
        for (int i = 0; i < OSR; i++) vec(bits, nact, km, run);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            s_valid = 1'b0;
            coef_we = 1'b0;
        end
    endtask

    task automatic wcoef(input int ch, input int idx, input logic [W-1:0] val, input bit ok);
        @(posedge clk); #1;
        s_valid    = 1'b0;
        coef_we    = 1'b1;
        coef_ch    = CH_W'(ch);
        coef_idx   = IX_W'(idx);
        coef_wdata = val;
        if (ok) coef_m[ch][idx] = val;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        idle(1);
        while (exp_val.size() != 0 && n < limit) begin
            idle(1);
            n++;
        end
        chk("drain_pending", 64'(exp_val.size()), 0);
        exp_val.delete();
        exp_cyc.delete();
    endtask

    task automatic chk_rst();
        chk("rst_est_valid", 64'(est_valid), 0);
        chk("rst_est_out", 64'(est_out), 0);
        chk("rst_start", 64'(bus.start), 0);
        chk("rst_enable_N", 64'(bus.enable_N), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_overrun", 64'(overrun), 0);
        chk("rst_K", 64'(bus.K), 0);
        chk("rst_S_matrix", 64'(bus.S_matrix), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; s_valid = 1'b0; s_in = '0; N_active = '0; K_mask = '0;
        coef_we = 1'b0; coef_ch = '0; coef_idx = '0; coef_wdata = '0;
        clr_models();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst();
        @(posedge clk); #1 resetn = 1'b1;

        // Unit coefficients on ch0/ch1, history filling with ones four taps per pass
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < K_MAX; k++) wcoef(c, k, 32'd1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            burst(8'h03, 2, (i == 5) ? 2'b01 : 2'b11, 1'b1);
            wait_done(200);
        end
        chk("K_latched", 64'(bus.K), 64'(2'b11));
        chk("busy_after_pass", 64'(busy), 0);
        chk("overrun_clear", 64'(overrun), 0);

        // Trigger while busy is dropped and overrun sticks
        burst(8'h01, 2, 2'b11, 1'b1);
        burst(8'h01, 2, 2'b11, 1'b0);
        idle(1);
        chk("overrun_set", 64'(overrun), 1);
        wait_done(200);
        idle(5);
        chk("overrun_sticky", 64'(overrun), 1);

        // Coefficient write during WAIT ignored, in IDLE accepted
        burst(8'h03, 2, 2'b11, 1'b1);
        idle(3);
        chk("busy_in_wait", 64'(busy), 1);
        wcoef(0, 0, 32'd7, 1'b0);
        wait_done(200);
        burst(8'h03, 2, 2'b11, 1'b1);
        wait_done(200);
        wcoef(0, 0, 32'd7, 1'b1);
        burst(8'h03, 2, 2'b11, 1'b1);
        wait_done(200);

        // Accumulator wraps without saturation
        force_max = 1'b1;
        burst(8'h03, 2, 2'b11, 1'b1);
        wait_done(200);
        force_max = 1'b0;

        // N_active of zero and above N_MAX
        wcoef(7, 1, 32'hFFFF_FFFD, 1'b1);
        ns = n_start;
        burst(8'hFF, 0, 2'b11, 1'b1);
        wait_done(50);
        chk("starts_n0", 64'(n_start - ns), 0);
        ns = n_start;
        burst(8'hFF, 9, 2'b11, 1'b1);
        wait_done(200);
        chk("starts_n9", 64'(n_start - ns), 8);

        // Reset during the WAIT of ch1 aborts the pass
        burst(8'h03, 2, 2'b11, 1'b0);
        idle(10);
        chk("busy_pre_reset", 64'(busy), 1);
        @(posedge clk); #1;
        resetn  = 1'b0;
        s_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        clr_models();
        @(negedge clk);
        chk_rst();
        for (int k = 0; k < 8; k++) begin
            wcoef(0, k, W'(k + 1), 1'b1);
            wcoef(1, k, 32'hFFFF_FFFE, 1'b1);
        end
        burst(8'h03, 2, 2'b11, 1'b1);
        wait_done(200);
        burst(8'h02, 2, 2'b11, 1'b1);
        wait_done(200);
        chk("overrun_after_reset", 64'(overrun), 0);

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
